// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: shares the single register-file write port between
// the MEM/WB pipeline outputs and an out-of-band multi-cycle (mul/div) result.
module wb_port_arbiter #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wb_regwrite,
   input  logic              wb_memtoreg,
   input  logic [DATA_W-1:0] wb_readdata,
   input  logic [DATA_W-1:0] wb_alu_result,
   input  logic [ADDR_W-1:0] wb_writereg,
   input  logic              mc_valid,
   output logic              mc_ready,
   input  logic [DATA_W-1:0] mc_data,
   input  logic [ADDR_W-1:0] mc_dest,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              pipe_stall,
   output logic              bubble_mem_wb,
   output logic              mc_pending
);

   localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      FORCE   = 2'd2,
      DRAIN   = 2'd3
   } state_t;

   state_t            state;
   logic [DATA_W-1:0] buf_data;
   logic [ADDR_W-1:0] buf_dest;
   logic [CNT_W-1:0]  wait_cnt;

   logic              slot_busy_c;
   logic              grant_c;
   logic [DATA_W-1:0] pipe_wdata_c;

   // A pipeline write to r0 is a no-op, so it leaves the slot free.
   assign slot_busy_c  = wb_regwrite && (wb_writereg != '0);
   assign pipe_wdata_c = wb_memtoreg ? wb_readdata : wb_alu_result;
   assign grant_c      = ((state == PENDING) || (state == DRAIN)) && !slot_busy_c;

   // Holding-register FSM; mc_ready/mc_pending are registered alongside state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         buf_data   <= '0;
         buf_dest   <= '0;
         wait_cnt   <= '0;
         mc_ready   <= 1'b1;
         mc_pending <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (mc_valid && (mc_dest != '0)) begin
                  buf_data   <= mc_data;
                  buf_dest   <= mc_dest;
                  wait_cnt   <= '0;
                  state      <= PENDING;
                  mc_ready   <= 1'b0;
                  mc_pending <= 1'b1;
               end
            end
            PENDING: begin
               if (!slot_busy_c) begin
                  state      <= IDLE;
                  mc_ready   <= 1'b1;
                  mc_pending <= 1'b0;
               end else if (wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
                  state <= FORCE;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            FORCE: begin
               state <= DRAIN;
            end
            DRAIN: begin
               // A busy slot here means MEM/WB ignored the bubble; retry it.
               if (!slot_busy_c) begin
                  state      <= IDLE;
                  mc_ready   <= 1'b1;
                  mc_pending <= 1'b0;
               end else begin
                  state <= FORCE;
               end
            end
            default: begin
               state      <= IDLE;
               mc_ready   <= 1'b1;
               mc_pending <= 1'b0;
            end
         endcase
      end
   end

   // Write-port mux and stall controls, combinational for same-cycle use.
   always_comb begin
      rf_we         = slot_busy_c;
      rf_waddr      = wb_writereg;
      rf_wdata      = pipe_wdata_c;
      pipe_stall    = 1'b0;
      bubble_mem_wb = 1'b0;
      if (grant_c) begin
         rf_we    = (buf_dest != '0);
         rf_waddr = buf_dest;
         rf_wdata = buf_data;
      end
      if (state == FORCE) begin
         pipe_stall    = 1'b1;
         bubble_mem_wb = 1'b1;
      end
      if (reset) begin
         rf_we         = 1'b0;
         pipe_stall    = 1'b0;
         bubble_mem_wb = 1'b0;
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter with MAX_WAIT=4 and hand-computed expectations.
module tb_wb_port_arbiter;

   logic        clk;
   logic        reset;
   logic        wb_regwrite;
   logic        wb_memtoreg;
   logic [31:0] wb_readdata;
   logic [31:0] wb_alu_result;
   logic [4:0]  wb_writereg;
   logic        mc_valid;
   logic        mc_ready;
   logic [31:0] mc_data;
   logic [4:0]  mc_dest;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        pipe_stall;
   logic        bubble_mem_wb;
   logic        mc_pending;

   int tests_run = 0;
   int tests_failed = 0;

   wb_port_arbiter #(.DATA_W(32), .ADDR_W(5), .MAX_WAIT(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .wb_regwrite   (wb_regwrite),
      .wb_memtoreg   (wb_memtoreg),
      .wb_readdata   (wb_readdata),
      .wb_alu_result (wb_alu_result),
      .wb_writereg   (wb_writereg),
      .mc_valid      (mc_valid),
      .mc_ready      (mc_ready),
      .mc_data       (mc_data),
      .mc_dest       (mc_dest),
      .rf_we         (rf_we),
      .rf_waddr      (rf_waddr),
      .rf_wdata      (rf_wdata),
      .pipe_stall    (pipe_stall),
      .bubble_mem_wb (bubble_mem_wb),
      .mc_pending    (mc_pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests_run++;
      assert (observed === expected)
      else begin
         tests_failed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Advance past the next rising edge; inputs change right after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      reset = 1'b1;
      wb_regwrite = 1'b1;
      wb_memtoreg = 1'b0;
      wb_readdata = 32'h0;
      wb_alu_result = 32'h5555;
      wb_writereg = 5'd5;
      mc_valid = 1'b0;
      mc_data = 32'h0;
      mc_dest = 5'd0;
      #12;
      chk("rst_rf_we", 32'(rf_we), 32'd0);
      chk("rst_mc_ready", 32'(mc_ready), 32'd1);
      chk("rst_pending", 32'(mc_pending), 32'd0);
      chk("rst_stall", 32'(pipe_stall), 32'd0);
      chk("rst_bubble", 32'(bubble_mem_wb), 32'd0);

      // Idle after reset
      tick();
      reset = 1'b0;
      wb_regwrite = 1'b0;
      settle();
      chk("idle_rf_we", 32'(rf_we), 32'd0);
      chk("idle_ready", 32'(mc_ready), 32'd1);
      chk("idle_stall", 32'(pipe_stall), 32'd0);

      // Pipeline pass-through, both data sources
      wb_regwrite = 1'b1; wb_writereg = 5'd5; wb_memtoreg = 1'b1;
      wb_readdata = 32'hAAAA; wb_alu_result = 32'hBBBB;
      settle();
      chk("pass_we", 32'(rf_we), 32'd1);
      chk("pass_addr", 32'(rf_waddr), 32'd5);
      chk("pass_load", rf_wdata, 32'hAAAA);
      wb_memtoreg = 1'b0;
      settle();
      chk("pass_alu", rf_wdata, 32'hBBBB);
      wb_writereg = 5'd0;
      settle();
      chk("pass_r0_we", 32'(rf_we), 32'd0);

      // Free slot: write one cycle after acceptance
      wb_regwrite = 1'b0;
      mc_valid = 1'b1; mc_data = 32'hDEADBEEF; mc_dest = 5'd7;
      tick();
      mc_valid = 1'b0;
      settle();
      chk("free_we", 32'(rf_we), 32'd1);
      chk("free_addr", 32'(rf_waddr), 32'd7);
      chk("free_data", rf_wdata, 32'hDEADBEEF);
      chk("free_ready_lo", 32'(mc_ready), 32'd0);
      chk("free_pending", 32'(mc_pending), 32'd1);
      tick();
      chk("free_ready_back", 32'(mc_ready), 32'd1);
      chk("free_we_after", 32'(rf_we), 32'd0);
      chk("free_pending_lo", 32'(mc_pending), 32'd0);

      // Pipeline priority: four busy cycles, one forced bubble, then drain
      wb_regwrite = 1'b1; wb_writereg = 5'd3; wb_alu_result = 32'h33;
      mc_valid = 1'b1; mc_data = 32'h1234; mc_dest = 5'd9;
      tick();
      mc_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         settle();
         chk("prio_busy_addr", 32'(rf_waddr), 32'd3);
         chk("prio_busy_data", rf_wdata, 32'h33);
         chk("prio_busy_stall", 32'(pipe_stall), 32'd0);
         tick();
      end
      chk("prio_force_stall", 32'(pipe_stall), 32'd1);
      chk("prio_force_bubble", 32'(bubble_mem_wb), 32'd1);
      chk("prio_force_we", 32'(rf_we), 32'd1);
      chk("prio_force_addr", 32'(rf_waddr), 32'd3);
      tick();
      wb_regwrite = 1'b0;
      settle();
      chk("prio_drain_stall", 32'(pipe_stall), 32'd0);
      chk("prio_drain_we", 32'(rf_we), 32'd1);
      chk("prio_drain_addr", 32'(rf_waddr), 32'd9);
      chk("prio_drain_data", rf_wdata, 32'h1234);
      tick();
      chk("prio_ready_back", 32'(mc_ready), 32'd1);

      // Slot frees after two busy cycles
      wb_regwrite = 1'b1; wb_writereg = 5'd3;
      mc_valid = 1'b1; mc_data = 32'hC0FFEE; mc_dest = 5'd12;
      tick();
      mc_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         settle();
         chk("mid_busy_addr", 32'(rf_waddr), 32'd3);
         chk("mid_busy_stall", 32'(pipe_stall), 32'd0);
         tick();
      end
      wb_regwrite = 1'b0;
      settle();
      chk("mid_grant_we", 32'(rf_we), 32'd1);
      chk("mid_grant_addr", 32'(rf_waddr), 32'd12);
      chk("mid_grant_data", rf_wdata, 32'hC0FFEE);
      chk("mid_grant_stall", 32'(pipe_stall), 32'd0);
      tick();
      chk("mid_pending_lo", 32'(mc_pending), 32'd0);

      // r0 result is accepted and dropped
      mc_valid = 1'b1; mc_data = 32'h55; mc_dest = 5'd0;
      tick();
      mc_valid = 1'b0;
      settle();
      chk("r0_pending", 32'(mc_pending), 32'd0);
      chk("r0_ready", 32'(mc_ready), 32'd1);
      chk("r0_we", 32'(rf_we), 32'd0);

      // Pipeline write to r0 counts as a free slot
      wb_regwrite = 1'b1; wb_writereg = 5'd0;
      mc_valid = 1'b1; mc_data = 32'hAB; mc_dest = 5'd10;
      tick();
      mc_valid = 1'b0;
      settle();
      chk("r0slot_we", 32'(rf_we), 32'd1);
      chk("r0slot_addr", 32'(rf_waddr), 32'd10);
      chk("r0slot_data", rf_wdata, 32'hAB);
      tick();

      // Slot still busy in drain: pipeline wins, bubble is retried
      wb_regwrite = 1'b1; wb_writereg = 5'd3;
      mc_valid = 1'b1; mc_data = 32'h44; mc_dest = 5'd4;
      tick();
      mc_valid = 1'b0;
      repeat (4) tick();
      chk("viol_force1", 32'(pipe_stall), 32'd1);
      tick();
      chk("viol_drain_stall", 32'(pipe_stall), 32'd0);
      chk("viol_drain_addr", 32'(rf_waddr), 32'd3);
      tick();
      chk("viol_force2", 32'(pipe_stall), 32'd1);
      tick();
      wb_regwrite = 1'b0;
      settle();
      chk("viol_grant_addr", 32'(rf_waddr), 32'd4);
      chk("viol_grant_data", rf_wdata, 32'h44);
      tick();

      // Reset during FORCE drops the result
      wb_regwrite = 1'b1; wb_writereg = 5'd3;
      mc_valid = 1'b1; mc_data = 32'h66; mc_dest = 5'd6;
      tick();
      mc_valid = 1'b0;
      repeat (4) tick();
      chk("rstf_stall_before", 32'(pipe_stall), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("rstf_stall_async", 32'(pipe_stall), 32'd0);
      chk("rstf_bubble_async", 32'(bubble_mem_wb), 32'd0);
      chk("rstf_we_async", 32'(rf_we), 32'd0);
      tick();
      reset = 1'b0;
      wb_regwrite = 1'b0;
      settle();
      chk("rstf_idle_pending", 32'(mc_pending), 32'd0);
      chk("rstf_idle_ready", 32'(mc_ready), 32'd1);
      for (int i = 0; i < 6; i++) begin
         settle();
         chk("rstf_no_write", 32'(rf_we), 32'd0);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
